// File: rtl/status_frame_reader.sv
// Reads a block of 64-bit status words from a 2-cycle-latency RAM and streams it
// out as a frame: one header word followed by the data words, with backpressure.
module status_frame_reader #(
    parameter logic [15:0] MAGIC      = 16'h5A5A,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic        sys_clk,
    input  logic        rst,
    input  logic        req,
    input  logic [6:0]  req_addr,
    input  logic [6:0]  req_len,
    output logic [6:0]  status_ram_addr,
    output logic        status_ram_rd_en,
    input  logic [63:0] status_ram_data,
    input  logic        status_ram_data_vld,
    output logic [63:0] tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        tx_last,
    output logic        busy,
    output logic        req_drop
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 2;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] HDR   = 2'd1;
    localparam logic [1:0] READ  = 2'd2;
    localparam logic [1:0] DRAIN = 2'd3;

    logic [1:0]    state_reg, state_next;
    logic [6:0]    start_addr_reg;
    logic [6:0]    rd_addr_reg;
    logic [7:0]    len_reg;
    logic [7:0]    reads_left_reg;
    logic [7:0]    sent_reg;
    logic [15:0]   seq_reg;
    logic [1:0]    rd_pipe_reg;
    logic          req_drop_reg;

    logic [63:0]   fifo_mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [AW:0]   fifo_count_reg;

    logic [CW-1:0] occupancy;
    logic          fifo_empty;
    logic          issue;
    logic          push;
    logic          pop;
    logic          hdr_acc;
    logic          data_phase;
    logic [63:0]   hdr_word;

    assign hdr_word   = {MAGIC, seq_reg, 17'b0, start_addr_reg, len_reg};
    assign fifo_empty = (fifo_count_reg == '0);
    assign data_phase = (state_reg == READ) || (state_reg == DRAIN);

    // Credit counts words already buffered plus reads still in the RAM pipeline,
    // so a returning word always has a free FIFO slot.
    assign occupancy = CW'(fifo_count_reg) + CW'(rd_pipe_reg[0]) + CW'(rd_pipe_reg[1]);
    assign issue     = (state_reg == READ) && !rst && (occupancy < CW'(FIFO_DEPTH));

    // Only returns matching our own read pipeline are accepted; this drops
    // returns for reads issued before a reset.
    assign push    = status_ram_data_vld && rd_pipe_reg[1];
    assign hdr_acc = (state_reg == HDR) && tx_ready;
    assign pop     = data_phase && !fifo_empty && tx_ready;

    assign tx_valid = (state_reg == HDR) || (data_phase && !fifo_empty);
    assign tx_data  = (state_reg == HDR) ? hdr_word : fifo_mem[rd_ptr_reg];
    assign tx_last  = data_phase && !fifo_empty && (sent_reg == len_reg - 8'd1);

    assign status_ram_rd_en = issue;
    assign status_ram_addr  = rd_addr_reg;
    assign busy             = (state_reg != IDLE);
    assign req_drop         = req_drop_reg;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (req) state_next = HDR;
            HDR:     if (tx_ready) state_next = READ;
            READ:    if (issue && (reads_left_reg == 8'd1)) state_next = DRAIN;
            DRAIN:   if (pop && tx_last) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            start_addr_reg <= '0;
            rd_addr_reg    <= '0;
            len_reg        <= '0;
            reads_left_reg <= '0;
            sent_reg       <= '0;
            seq_reg        <= '0;
            rd_pipe_reg    <= '0;
            req_drop_reg   <= 1'b0;
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            fifo_count_reg <= '0;
        end else begin
            state_reg    <= state_next;
            req_drop_reg <= req && (state_reg != IDLE);
            rd_pipe_reg  <= {rd_pipe_reg[0], issue};

            if ((state_reg == IDLE) && req) begin
                start_addr_reg <= req_addr;
                rd_addr_reg    <= req_addr;
                len_reg        <= (req_len == 7'd0) ? 8'd128 : {1'b0, req_len};
                reads_left_reg <= (req_len == 7'd0) ? 8'd128 : {1'b0, req_len};
                sent_reg       <= '0;
            end

            if (issue) begin
                rd_addr_reg    <= rd_addr_reg + 7'd1;
                reads_left_reg <= reads_left_reg - 8'd1;
            end

            if (hdr_acc)
                seq_reg <= seq_reg + 16'd1;

            if (push)
                wr_ptr_reg <= wr_ptr_reg + AW'(1);

            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
                sent_reg   <= sent_reg + 8'd1;
            end

            case ({push, pop})
                2'b10:   fifo_count_reg <= fifo_count_reg + (AW+1)'(1);
                2'b01:   fifo_count_reg <= fifo_count_reg - (AW+1)'(1);
                default: fifo_count_reg <= fifo_count_reg;
            endcase
        end
    end

    always_ff @(posedge sys_clk) begin
        if (push)
            fifo_mem[wr_ptr_reg] <= status_ram_data;
    end

endmodule

// File: tb/tb_status_frame_reader.sv
// Scoreboard bench for status_frame_reader: stimulus queues expected words,
// a negedge monitor pops and compares every accepted tx word.
module tb_status_frame_reader;

    logic        sys_clk = 1'b0;
    logic        rst;
    logic        req;
    logic [6:0]  req_addr;
    logic [6:0]  req_len;
    logic [6:0]  status_ram_addr;
    logic        status_ram_rd_en;
    logic [63:0] status_ram_data;
    logic        status_ram_data_vld;
    logic [63:0] tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        tx_last;
    logic        busy;
    logic        req_drop;

    always #5 sys_clk = ~sys_clk;

    status_frame_reader dut (
        .sys_clk             (sys_clk),
        .rst                 (rst),
        .req                 (req),
        .req_addr            (req_addr),
        .req_len             (req_len),
        .status_ram_addr     (status_ram_addr),
        .status_ram_rd_en    (status_ram_rd_en),
        .status_ram_data     (status_ram_data),
        .status_ram_data_vld (status_ram_data_vld),
        .tx_data             (tx_data),
        .tx_valid            (tx_valid),
        .tx_ready            (tx_ready),
        .tx_last             (tx_last),
        .busy                (busy),
        .req_drop            (req_drop)
    );

    function automatic logic [63:0] ram_word(input logic [6:0] a);
        return {32'hC0DE_0000 | {25'd0, a}, 32'h0F0F_0000 ^ {25'd0, a}};
    endfunction

    // RAM model: fixed 2-cycle read latency, keeps running through reset
    logic       p1, p2;
    logic [6:0] a1, a2;
    always @(posedge sys_clk) begin
        p1 <= status_ram_rd_en;
        a1 <= status_ram_addr;
        p2 <= p1;
        a2 <= a1;
    end
    assign status_ram_data_vld = p2;
    assign status_ram_data     = ram_word(a2);

    typedef struct {
        logic [63:0] data;
        logic        last;
        logic        hdr;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;

    int n_checks = 0;
    int n_fail   = 0;
    int ready_mode = 0;
    int cyc = 0;
    int data_acc = 0;
    int issued = 0;
    int max_out = 0;
    int hdr_cyc = 0, first_cyc = 0, last_cyc = 0;
    logic        prev_stall = 1'b0;
    logic [63:0] prev_data = '0;
    logic        prev_last = 1'b0;

    task automatic chk64(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", name, got, exp);
        end else
            $display("ok   %s: %h", name, got);
    endtask

    task automatic chk1(input string name, input logic got, input logic exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b required %b", name, got, exp);
        end else
            $display("ok   %s: %b", name, got);
    endtask

    task automatic chk_int(input string name, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d required %0d", name, got, exp);
        end else
            $display("ok   %s: %0d", name, got);
    endtask

    // tx_ready driver: 0 = held high, 1 = toggling, 2 = held low
    initial begin
        tx_ready = 1'b1;
        forever begin
            @(posedge sys_clk);
            #1;
            case (ready_mode)
                0:       tx_ready = 1'b1;
                1:       tx_ready = ~tx_ready;
                default: tx_ready = 1'b0;
            endcase
        end
    end

    // Monitor / scoreboard
    always @(negedge sys_clk) begin
        cyc++;
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk1("hold_valid", tx_valid, 1'b1);
                chk64("hold_data", tx_data, prev_data);
                chk1("hold_last", tx_last, prev_last);
            end
            if (status_ram_rd_en) begin
                issued++;
                if (issued - data_acc > max_out)
                    max_out = issued - data_acc;
            end
            if (tx_valid && tx_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_word: got %h last %b required no word", tx_data, tx_last);
                end else begin
                    e = exp_q.pop_front();
                    chk64(e.hdr ? "hdr_data" : "word_data", tx_data, e.data);
                    chk1(e.hdr ? "hdr_last" : "word_last", tx_last, e.last);
                    if (e.hdr)
                        hdr_cyc = cyc;
                    else begin
                        if (data_acc == 0)
                            first_cyc = cyc;
                        last_cyc = cyc;
                        data_acc++;
                    end
                end
            end
            prev_stall = tx_valid && !tx_ready;
            prev_data  = tx_data;
            prev_last  = tx_last;
        end
    end

    task automatic start_frame(input logic [6:0] a, input logic [6:0] l, input logic [63:0] hdr);
        int   n;
        exp_t x;
        n = (l == 7'd0) ? 128 : int'(l);
        x.data = hdr;
        x.last = 1'b0;
        x.hdr  = 1'b1;
        exp_q.push_back(x);
        for (int i = 0; i < n; i++) begin
            x.data = ram_word(a + 7'(i));
            x.last = (i == n - 1);
            x.hdr  = 1'b0;
            exp_q.push_back(x);
        end
        issued   = 0;
        data_acc = 0;
        max_out  = 0;
        req      = 1'b1;
        req_addr = a;
        req_len  = l;
        @(posedge sys_clk);
        #1;
        req = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < 3000) begin
            @(posedge sys_clk);
            #2;
            k++;
        end
        if (exp_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_timeout: %0d words still expected, required 0", name, exp_q.size());
            exp_q.delete();
        end
        chk1("busy_fall", busy, 1'b0);
    endtask

    task automatic wait_data(input int count);
        int k;
        k = 0;
        while (data_acc < count && k < 500) begin
            @(posedge sys_clk);
            #2;
            k++;
        end
        if (data_acc < count) begin
            n_checks++;
            n_fail++;
            $display("FAIL wait_data_timeout: got %0d words required %0d", data_acc, count);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int snap;
        rst      = 1'b1;
        req      = 1'b0;
        req_addr = '0;
        req_len  = '0;
        repeat (3) @(posedge sys_clk);
        #1;
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_tx_valid", tx_valid, 1'b0);
        chk1("rst_tx_last", tx_last, 1'b0);
        chk1("rst_rd_en", status_ram_rd_en, 1'b0);
        chk1("rst_req_drop", req_drop, 1'b0);
        rst = 1'b0;
        @(posedge sys_clk);
        #1;

        // addr 64, len 5, ready high; a second request mid-frame is dropped
        ready_mode = 0;
        start_frame(7'd64, 7'd5, 64'h5A5A_0000_0000_4005);
        chk1("busy_rise", busy, 1'b1);
        @(posedge sys_clk);
        #1;
        req      = 1'b1;
        req_addr = 7'd3;
        req_len  = 7'd9;
        @(posedge sys_clk);
        #1;
        req = 1'b0;
        chk1("req_drop_pulse", req_drop, 1'b1);
        @(posedge sys_clk);
        #1;
        chk1("req_drop_clear", req_drop, 1'b0);
        wait_done("frame64");
        chk1("first_data_latency_le4", (first_cyc - hdr_cyc) <= 4, 1'b1);
        chk_int("sustained_rate", last_cyc - first_cyc, 4);

        // back-to-back, address wrap 126,127,0,1; header seq 1
        start_frame(7'd126, 7'd4, 64'h5A5A_0001_0000_7E04);
        wait_done("wrap");

        // len 0 = 128 words, ready toggling
        ready_mode = 1;
        start_frame(7'h20, 7'd0, 64'h5A5A_0002_0000_2080);
        wait_done("len128");
        chk_int("len128_words", data_acc, 128);
        chk1("len128_outstanding_le4", max_out <= 4, 1'b1);

        // 20-cycle stall mid-frame
        ready_mode = 0;
        start_frame(7'd10, 7'd10, 64'h5A5A_0003_0000_0A0A);
        wait_data(3);
        ready_mode = 2;
        repeat (5) @(posedge sys_clk);
        snap = issued;
        repeat (15) @(posedge sys_clk);
        chk_int("stall_no_reads", issued - snap, 0);
        chk1("stall_reads_pending", issued < 10, 1'b1);
        chk1("stall_outstanding_le4", max_out <= 4, 1'b1);
        ready_mode = 0;
        wait_done("stall");
        chk_int("stall_words", data_acc, 10);

        // reset after 3 of 8 words; req during reset ignored; seq restarts
        start_frame(7'h30, 7'd8, 64'h5A5A_0004_0000_3008);
        wait_data(3);
        rst      = 1'b1;
        req      = 1'b1;
        req_addr = 7'd1;
        req_len  = 7'd1;
        exp_q.delete();
        @(posedge sys_clk);
        #1;
        rst = 1'b0;
        req = 1'b0;
        chk1("midrst_busy", busy, 1'b0);
        chk1("midrst_tx_valid", tx_valid, 1'b0);
        chk1("midrst_tx_last", tx_last, 1'b0);
        chk1("midrst_rd_en", status_ram_rd_en, 1'b0);
        chk1("midrst_req_drop", req_drop, 1'b0);
        repeat (6) @(posedge sys_clk);
        #1;
        chk1("rst_req_ignored", busy, 1'b0);
        start_frame(7'd5, 7'd3, 64'h5A5A_0000_0000_0503);
        wait_done("after_rst");
        chk_int("after_rst_words", data_acc, 3);

        repeat (3) @(posedge sys_clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/status_frame_reader.md
STATUS_FRAME_READER -- requirements
Module: status_frame_reader

Interface
REQ-001 SHALL have parameter MAGIC, default 16'h5A5A, header-word marker.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, output buffer depth in 64-bit words (power of 2, >=4).
REQ-003 SHALL have port sys_clk  input  1  single clock for all logic.
REQ-004 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-005 SHALL have port req  input  1  one-cycle frame request strobe.
REQ-006 SHALL have port req_addr  input  7  first status RAM word address (64-bit word units).
REQ-007 SHALL have port req_len  input  7  word count; 0 encodes 128.
REQ-008 SHALL have port status_ram_addr  output  7  status RAM read address.
REQ-009 SHALL have port status_ram_rd_en  output  1  status RAM read strobe.
REQ-010 SHALL have port status_ram_data  input  64  status RAM read data.
REQ-011 SHALL have port status_ram_data_vld  input  1  read data valid, exactly 2 cycles after status_ram_rd_en.
REQ-012 SHALL have port tx_data  output  64  frame stream data.
REQ-013 SHALL have port tx_valid  output  1  tx_data valid.
REQ-014 SHALL have port tx_ready  input  1  downstream accept.
REQ-015 SHALL have port tx_last  output  1  marks final word of frame.
REQ-016 SHALL have port busy  output  1  frame in progress.
REQ-017 SHALL have port req_drop  output  1  one-cycle pulse: request ignored.

Function
REQ-018 SHALL use FSM states IDLE, HDR, READ, DRAIN; IDLE->HDR on req; HDR->READ when header accepted; READ->DRAIN after last read issued; DRAIN->IDLE when tx_last word accepted.
REQ-019 On req in IDLE, SHALL latch req_addr, req_len (N = req_len==0 ? 128 : req_len) and assert busy next cycle.
REQ-020 req while busy SHALL be ignored and SHALL pulse req_drop 1 cycle later; latched frame unaffected.
REQ-021 Header word SHALL be {MAGIC, seq[15:0], 17'b0, start_addr[6:0], N[7:0]}, tx_last=0, presented in HDR with tx_valid=1.
REQ-022 seq SHALL be 16-bit, 0 after reset, incremented when header accepted, wrapping FFFF->0000.
REQ-023 In READ, SHALL issue exactly N reads, addresses start_addr, start_addr+1, ..., modulo 128 (7F wraps to 00).
REQ-024 SHALL issue a read only when (FIFO occupancy + reads in flight) < FIFO_DEPTH; no FIFO overflow under any tx_ready pattern.
REQ-025 Each status_ram_data_vld SHALL push status_ram_data unchanged into FIFO; data words output in address order.
REQ-026 Data word N SHALL carry tx_last=1; all other words tx_last=0.
REQ-027 Word transfer SHALL occur iff tx_valid & tx_ready; tx_data/tx_last SHALL hold stable while tx_valid & !tx_ready.
REQ-028 With tx_ready held 1, SHALL sustain one data word per cycle; first data word at most 4 cycles after header accept.
REQ-029 status_ram_rd_en SHALL be 0 outside READ; status_ram_addr value irrelevant when rd_en=0.
REQ-030 Back-to-back frames: req accepted in cycle after busy falls SHALL start a new frame normally.

Reset
REQ-031 While rst=1, SHALL force: state IDLE, busy=0, tx_valid=0, tx_last=0, status_ram_rd_en=0, req_drop=0, seq=0, FIFO empty, in-flight count 0.
REQ-032 rst mid-frame SHALL abort the frame; data_vld arriving in 2 cycles after rst release for pre-reset reads SHALL be discarded.
REQ-033 req asserted during rst SHALL be ignored.

Verification
REQ-034 req_addr=64, req_len=5, tx_ready=1 -> header {5A5A,0000,0,0x40,0x05}, then data of addrs 64..68, tx_last on 5th, busy falls after.
REQ-035 req_addr=126, req_len=4 -> reads 126,127,0,1 in order; tx_last on word from addr 1.
REQ-036 req_len=0, tx_ready toggling 1/0 every cycle -> 1 header + 128 data words, none lost/duplicated, FIFO never exceeds 4.
REQ-037 tx_ready=0 for 20 cycles mid-frame -> at most 4 words buffered, reads stall, tx_data stable, resume in order.
REQ-038 Second req while busy -> req_drop pulse, frame unchanged; next accepted frame header seq=0001.
REQ-039 rst asserted after 3 of 8 words sent -> all outputs reset values next cycle; new req afterwards -> header seq=0000, no stale data.
